// File: rtl/data_sram_resp.sv
// One-cycle-latency data SRAM responder with byte writes, a read-only display port
// and a sticky out-of-window flag. Define DSRAM_WRITE_FIRST_EN for write-first rdata.
module data_sram_resp #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        addr_err
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic                  addr_err_q, addr_err_d;

  logic [ADDR_WIDTH-1:0] a_idx_c, d_idx_c;
  logic                  a_hit_c, d_hit_c;
  logic [31:0]           old_c, merged_c;
  logic                  we_c;
  logic                  unused_c;

  assign a_idx_c  = data_sram_addr[TAG_LSB-1:2];
  assign d_idx_c  = mem_addr[TAG_LSB-1:2];
  assign a_hit_c  = (data_sram_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign d_hit_c  = (mem_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign old_c    = mem_q[a_idx_c];
  assign we_c     = !reset && data_sram_en && a_hit_c && (data_sram_wen != 4'b0000);
  assign unused_c = ^{data_sram_addr[1:0], mem_addr[1:0]};

  // Old word with the enabled bytes replaced by write data.
  always_comb begin
    merged_c = old_c;
    for (int i = 0; i < 4; i++) begin
      if (data_sram_wen[i]) merged_c[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata_d    = rdata_q;
    addr_err_d = addr_err_q;
    mem_data_d = d_hit_c ? mem_q[d_idx_c] : 32'h0;
    if (data_sram_en) begin
      if (!a_hit_c) begin
        rdata_d    = 32'h0;
        addr_err_d = 1'b1;
      end else if (data_sram_wen == 4'b0000) begin
        rdata_d = old_c;
      end else begin
`ifdef DSRAM_WRITE_FIRST_EN
        rdata_d = merged_c;
`else
        rdata_d = old_c;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q    <= 32'h0;
      mem_data_q <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      mem_data_q <= mem_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array is never cleared; reset only blocks writes through we_c.
  always_ff @(posedge clk) begin
    if (we_c) mem_q[a_idx_c] <= merged_c;
  end

  assign data_sram_rdata = rdata_q;
  assign mem_data        = mem_data_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_data_sram_resp;

  localparam int unsigned AW    = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] OOR   = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mdl [256];
  logic [31:0] exp_rdata;
  logic [31:0] exp_mem_data;
  logic        exp_err;

  data_sram_resp #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .addr_err        (addr_err)
  );

  always #5 clk = ~clk;

  function automatic bit in_win(input logic [31:0] a);
    return (a >> (AW + 2)) == (BASE >> (AW + 2));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  // Drive one cycle, predict outputs from the model, then commit the model write.
  task automatic step(input logic rst, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] maddr);
    logic [31:0] oldw, neww;
    reset = rst; data_sram_en = en; data_sram_wen = wen;
    data_sram_addr = addr; data_sram_wdata = wdata; mem_addr = maddr;
    oldw = mdl[widx(addr)];
    neww = oldw;
    for (int b = 0; b < 4; b++) if (wen[b]) neww[8*b +: 8] = wdata[8*b +: 8];
    if (rst) begin
      exp_rdata = 32'h0; exp_mem_data = 32'h0; exp_err = 1'b0;
    end else begin
      exp_mem_data = in_win(maddr) ? mdl[widx(maddr)] : 32'h0;
      if (en && !in_win(addr)) begin
        exp_rdata = 32'h0; exp_err = 1'b1;
      end else if (en) begin
`ifdef DSRAM_WRITE_FIRST_EN
        exp_rdata = neww;
`else
        exp_rdata = oldw;
`endif
        mdl[widx(addr)] = neww;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] maddr);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, maddr);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, OOR);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, OOR);
    idle(OOR);
    n_tests += 3;
    if (data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want %h", data_sram_rdata, 32'h0); end
    if (mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_data got %h want %h", mem_data, 32'h0); end
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
    step(1'b0, 1'b1, 4'hF, 32'h10, 32'h0, OOR);
    step(1'b0, 1'b1, 4'hF, 32'h0, 32'h0, OOR);
    step(1'b1, 1'b1, 4'hF, 32'h10, 32'h1122_3344, OOR);
    step(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, OOR);
    n_tests++;
    if (data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_write_suppressed got %h want %h", data_sram_rdata, 32'h0); end
  endtask

  task automatic test_write_read;
    step(1'b0, 1'b1, 4'hF, 32'h10, 32'hAABB_CCDD, OOR);
    step(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, OOR);
    n_tests++;
    if (data_sram_rdata !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL write_then_read got %h want %h", data_sram_rdata, 32'hAABB_CCDD); end
    for (int i = 0; i < 3; i++) begin
      idle(OOR);
      n_tests++;
      if (data_sram_rdata !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL idle_hold_%0d got %h want %h", i, data_sram_rdata, 32'hAABB_CCDD); end
    end
  endtask

  task automatic test_byte_en;
    step(1'b0, 1'b1, 4'b0101, 32'h10, 32'h1122_3344, OOR);
    step(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, OOR);
    n_tests++;
    if (data_sram_rdata !== 32'hAA22_CC44) begin n_fail++; $display("FAIL byte_en_0101 got %h want %h", data_sram_rdata, 32'hAA22_CC44); end
    step(1'b0, 1'b1, 4'b0110, 32'h10, 32'h5566_7788, OOR);
    step(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, OOR);
    n_tests++;
    if (data_sram_rdata !== 32'hAA66_7744) begin n_fail++; $display("FAIL byte_en_0110 got %h want %h", data_sram_rdata, 32'hAA66_7744); end
  endtask

  task automatic test_write_rdata;
    logic [31:0] want;
`ifdef DSRAM_WRITE_FIRST_EN
    want = 32'hFFFF_0000;
`else
    want = 32'h0;
`endif
    step(1'b0, 1'b1, 4'hF, 32'h10, 32'h0, OOR);
    step(1'b0, 1'b1, 4'hF, 32'h10, 32'hFFFF_0000, OOR);
    n_tests++;
    if (data_sram_rdata !== want) begin n_fail++; $display("FAIL write_cycle_rdata got %h want %h", data_sram_rdata, want); end
  endtask

  task automatic test_display;
    step(1'b0, 1'b1, 4'hF, 32'h10, 32'h1234_5678, 32'h10);
    n_tests++;
    if (mem_data !== 32'hFFFF_0000) begin n_fail++; $display("FAIL display_read_first got %h want %h", mem_data, 32'hFFFF_0000); end
    idle(32'h13);
    n_tests += 2;
    if (mem_data !== 32'h1234_5678) begin n_fail++; $display("FAIL display_new_word got %h want %h", mem_data, 32'h1234_5678); end
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL err_before_range got %b want 0", addr_err); end
    idle(OOR);
    n_tests += 2;
    if (mem_data !== 32'h0) begin n_fail++; $display("FAIL display_oor got %h want %h", mem_data, 32'h0); end
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL display_oor_no_err got %b want 0", addr_err); end
  endtask

  task automatic test_range;
    step(1'b0, 1'b1, 4'hF, 32'h0, 32'h5555_AAAA, OOR);
    step(1'b0, 1'b1, 4'h0, 32'h0, 32'h0, OOR);
    step(1'b0, 1'b1, 4'h0, OOR, 32'h0, OOR);
    n_tests += 2;
    if (data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_read_rdata got %h want %h", data_sram_rdata, 32'h0); end
    if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_read_err got %b want 1", addr_err); end
    step(1'b0, 1'b1, 4'hF, OOR, 32'hDEAD_BEEF, OOR);
    step(1'b0, 1'b1, 4'h0, 32'h0, 32'h0, OOR);
    n_tests += 2;
    if (data_sram_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL oor_write_no_alias got %h want %h", data_sram_rdata, 32'h5555_AAAA); end
    if (addr_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", addr_err); end
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, OOR);
    n_tests++;
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared_by_reset got %b want 0", addr_err); end
  endtask

  task automatic test_random;
    logic        en, rst;
    logic [3:0]  wen;
    logic [31:0] addr, maddr;
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 4'hF, BASE + 32'(i * 4), $urandom, OOR);
    step(1'b0, 1'b1, 4'h0, BASE, 32'h0, OOR);
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      en    = ($urandom_range(0, 3) != 0);
      wen   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      addr  = ($urandom_range(0, 9) == 0) ? ($urandom | OOR) : (BASE + 32'($urandom_range(0, 1023)));
      maddr = ($urandom_range(0, 7) == 0) ? ($urandom | OOR) : (BASE + 32'($urandom_range(0, 1023)));
      step(rst, en, wen, addr, $urandom, maddr);
      n_tests += 3;
      if (data_sram_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d] got %h want %h", i, data_sram_rdata, exp_rdata); end
      if (mem_data !== exp_mem_data) begin n_fail++; $display("FAIL rand_mem_data[%0d] got %h want %h", i, mem_data, exp_mem_data); end
      if (addr_err !== exp_err) begin n_fail++; $display("FAIL rand_addr_err[%0d] got %b want %b", i, addr_err, exp_err); end
    end
  endtask

  initial begin
    reset = 1'b1; data_sram_en = 1'b0; data_sram_wen = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0; mem_addr = OOR;
    exp_rdata = 32'h0; exp_mem_data = 32'h0; exp_err = 1'b0;
    test_reset();
    test_write_read();
    test_byte_en();
    test_write_rdata();
    test_display();
    test_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
